// File: rtl/uart_fifo_ctrl_if.sv
// Push/pop handshake and uart_ram port bundle for uart_fifo_ctrl.
// master = surrounding logic (byte engine, bus side, RAM model); slave = the controller.
interface uart_fifo_ctrl_if #(
  parameter int unsigned DATA_BIT = 8,
  parameter int unsigned ADDR_BIT = 4
) ();
  logic                wr_en;
  logic [DATA_BIT-1:0] wr_data;
  logic                full;
  logic                rd_en;
  logic [DATA_BIT-1:0] rd_data;
  logic                rd_valid;
  logic [ADDR_BIT:0]   level;
  logic                ram_we;
  logic [ADDR_BIT-1:0] ram_waddr;
  logic [DATA_BIT-1:0] ram_wdata;
  logic [ADDR_BIT-1:0] ram_raddr;
  logic [DATA_BIT-1:0] ram_rdata;

  modport master (
    output wr_en, wr_data, rd_en, ram_rdata,
    input  full, rd_data, rd_valid, level, ram_we, ram_waddr, ram_wdata, ram_raddr
  );

  modport slave (
    input  wr_en, wr_data, rd_en, ram_rdata,
    output full, rd_data, rd_valid, level, ram_we, ram_waddr, ram_wdata, ram_raddr
  );
endinterface

// File: rtl/uart_fifo_ctrl.sv
// First-word-fall-through FIFO controller around a registered-read uart_ram.
// Optional sticky overflow/underflow flags when UART_FIFO_CTRL_STATUS_EN is defined.
module uart_fifo_ctrl #(
  parameter int unsigned DATA_BIT = 8,
  parameter int unsigned ADDR_BIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
`ifdef UART_FIFO_CTRL_STATUS_EN
  input  logic            status_clr,
  output logic            overflow,
  output logic            underflow,
`endif
  uart_fifo_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = ADDR_BIT + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_BIT;

  logic [ADDR_BIT-1:0] r_wr_ptr;
  logic [ADDR_BIT-1:0] r_rd_ptr;
  logic [CNT_W-1:0]    r_ram_count;
  logic [CNT_W-1:0]    r_level;
  logic                r_fetch_pending;
  logic                r_rd_valid;
  logic                r_full;
  logic [DATA_BIT-1:0] r_rd_data;

  logic                w_clear;
  logic                w_push;
  logic                w_pop;
  logic                w_fetch;
  logic [CNT_W-1:0]    w_ram_count_nxt;
  logic [CNT_W-1:0]    w_level_nxt;

  assign w_clear = reset | flush;
  assign w_push  = bus.wr_en & ~r_full & ~w_clear;
  assign w_pop   = bus.rd_en & r_rd_valid & ~w_clear;
  // Registered ram_count keeps a fetch off the address being written this cycle.
  assign w_fetch = (r_ram_count != '0) & ~r_fetch_pending & (~r_rd_valid | w_pop) & ~w_clear;

  always_comb begin
    w_ram_count_nxt = r_ram_count;
    w_level_nxt     = r_level;
    if (w_push && !w_fetch) begin
      w_ram_count_nxt = r_ram_count + CNT_W'(1);
    end else if (!w_push && w_fetch) begin
      w_ram_count_nxt = r_ram_count - CNT_W'(1);
    end
    // Words only enter on push and leave on pop; fetch/capture move them internally.
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_level_nxt = r_level - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_ram_count     <= '0;
      r_level         <= '0;
      r_fetch_pending <= 1'b0;
      r_rd_valid      <= 1'b0;
      r_full          <= 1'b0;
      r_rd_data       <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_BIT'(1);
      end
      if (w_fetch) begin
        r_rd_ptr <= r_rd_ptr + ADDR_BIT'(1);
      end
      r_ram_count     <= w_ram_count_nxt;
      r_level         <= w_level_nxt;
      r_full          <= (w_ram_count_nxt == CNT_W'(DEPTH));
      r_fetch_pending <= w_fetch;
      if (r_fetch_pending) begin
        r_rd_data  <= bus.ram_rdata;
        r_rd_valid <= 1'b1;
      end else if (w_pop) begin
        r_rd_valid <= 1'b0;
      end
    end
  end

  assign bus.ram_we    = w_push;
  assign bus.ram_waddr = r_wr_ptr;
  assign bus.ram_wdata = bus.wr_data;
  assign bus.ram_raddr = r_rd_ptr;
  assign bus.full      = r_full;
  assign bus.rd_data   = r_rd_data;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.level     = r_level;

`ifdef UART_FIFO_CTRL_STATUS_EN
  logic r_overflow;
  logic r_underflow;
  logic w_ovf_set;
  logic w_udf_set;

  assign w_ovf_set = bus.wr_en & r_full;
  assign w_udf_set = bus.rd_en & ~r_rd_valid;

  // Sticky flags; a set event beats status_clr in the same cycle.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_ovf_set | (r_overflow & ~status_clr);
      r_underflow <= w_udf_set | (r_underflow & ~status_clr);
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed bench for uart_fifo_ctrl: vector table plus hand-written multi-cycle sequences.
// Status-flag checks compile in only when UART_FIFO_CTRL_STATUS_EN is defined.
module tb_uart_fifo_ctrl;
  localparam int unsigned DATA_BIT = 8;
  localparam int unsigned ADDR_BIT = 4;
  localparam int unsigned DEPTH    = 16;

  logic clk = 1'b0;
  logic reset;
  logic flush;
`ifdef UART_FIFO_CTRL_STATUS_EN
  logic status_clr;
  logic overflow;
  logic underflow;
`endif

  uart_fifo_ctrl_if #(.DATA_BIT(DATA_BIT), .ADDR_BIT(ADDR_BIT)) bus ();

  uart_fifo_ctrl #(.DATA_BIT(DATA_BIT), .ADDR_BIT(ADDR_BIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
`ifdef UART_FIFO_CTRL_STATUS_EN
    .status_clr(status_clr),
    .overflow  (overflow),
    .underflow (underflow),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // uart_ram model: registered read, no reset
  logic [7:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_raddr];
  end

  int n_vec = 0;
  int n_err = 0;
  int n_popped;
  logic [7:0] q[$];

  typedef struct {
    logic       fl;
    logic       we;
    logic [7:0] wd;
    logic       re;
    logic       e_we;
    logic [3:0] e_wa;
    logic [3:0] e_ra;
    logic       e_v;
    logic [7:0] e_d;
    logic       e_f;
    logic [4:0] e_l;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at negedge; outputs are sampled on return, before the posedge.
  task automatic step(input logic fl, input logic we, input logic [7:0] wd, input logic re);
    @(negedge clk);
    flush       = fl;
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    flush       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.rd_en   = 1'b0;
`ifdef UART_FIFO_CTRL_STATUS_EN
    status_clr  = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    n_popped = 0;
  endtask

  // Pop until the scoreboard is empty, comparing each word in order.
  task automatic drain(input string name, input int max_cycles);
    for (int c = 0; c < max_cycles && q.size() > 0; c++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      if (bus.rd_valid) begin
        check($sformatf("%s.data%0d", name, n_popped), int'(bus.rd_data), int'(q.pop_front()));
        n_popped++;
      end
    end
    check($sformatf("%s.drain_left", name), q.size(), 0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check($sformatf("%s.empty_valid", name), int'(bus.rd_valid), 0);
    check($sformatf("%s.empty_level", name), int'(bus.level), 0);
    check($sformatf("%s.empty_full", name), int'(bus.full), 0);
  endtask

  initial begin
    reset       = 1'b1;
    flush       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.rd_en   = 1'b0;
`ifdef UART_FIFO_CTRL_STATUS_EN
    status_clr  = 1'b0;
`endif

    //            fl  we  wd     re | we  wa  ra  v   d      f   lvl
    tbl[0]  = '{1'b0,1'b1,8'hA5,1'b0, 1'b1,4'd0,4'd0,1'b0,8'h00,1'b0,5'd0};
    tbl[1]  = '{1'b0,1'b0,8'h00,1'b0, 1'b0,4'd1,4'd0,1'b0,8'h00,1'b0,5'd1};
    tbl[2]  = '{1'b0,1'b0,8'h00,1'b0, 1'b0,4'd1,4'd1,1'b0,8'h00,1'b0,5'd1};
    tbl[3]  = '{1'b0,1'b0,8'h00,1'b1, 1'b0,4'd1,4'd1,1'b1,8'hA5,1'b0,5'd1};
    tbl[4]  = '{1'b0,1'b0,8'h00,1'b1, 1'b0,4'd1,4'd1,1'b0,8'hA5,1'b0,5'd0};
    tbl[5]  = '{1'b0,1'b0,8'h00,1'b0, 1'b0,4'd1,4'd1,1'b0,8'hA5,1'b0,5'd0};
    tbl[6]  = '{1'b0,1'b1,8'h11,1'b0, 1'b1,4'd1,4'd1,1'b0,8'hA5,1'b0,5'd0};
    tbl[7]  = '{1'b0,1'b1,8'h22,1'b0, 1'b1,4'd2,4'd1,1'b0,8'hA5,1'b0,5'd1};
    tbl[8]  = '{1'b0,1'b0,8'h00,1'b0, 1'b0,4'd3,4'd2,1'b0,8'hA5,1'b0,5'd2};
    tbl[9]  = '{1'b0,1'b0,8'h00,1'b1, 1'b0,4'd3,4'd2,1'b1,8'h11,1'b0,5'd2};
    tbl[10] = '{1'b0,1'b0,8'h00,1'b1, 1'b0,4'd3,4'd3,1'b0,8'h11,1'b0,5'd1};
    tbl[11] = '{1'b0,1'b0,8'h00,1'b1, 1'b0,4'd3,4'd3,1'b1,8'h22,1'b0,5'd1};
    tbl[12] = '{1'b0,1'b0,8'h00,1'b0, 1'b0,4'd3,4'd3,1'b0,8'h22,1'b0,5'd0};
    tbl[13] = '{1'b0,1'b1,8'h33,1'b0, 1'b1,4'd3,4'd3,1'b0,8'h22,1'b0,5'd0};
    tbl[14] = '{1'b1,1'b1,8'h44,1'b0, 1'b0,4'd4,4'd3,1'b0,8'h22,1'b0,5'd1};
    tbl[15] = '{1'b0,1'b0,8'h00,1'b0, 1'b0,4'd0,4'd0,1'b0,8'h00,1'b0,5'd0};

    // Vector table: single-word latency, back-to-back push/pop, flush over a push
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].fl, tbl[i].we, tbl[i].wd, tbl[i].re);
      check($sformatf("v%0d.ram_we", i),    int'(bus.ram_we),    int'(tbl[i].e_we));
      check($sformatf("v%0d.ram_waddr", i), int'(bus.ram_waddr), int'(tbl[i].e_wa));
      check($sformatf("v%0d.ram_raddr", i), int'(bus.ram_raddr), int'(tbl[i].e_ra));
      check($sformatf("v%0d.rd_valid", i),  int'(bus.rd_valid),  int'(tbl[i].e_v));
      check($sformatf("v%0d.rd_data", i),   int'(bus.rd_data),   int'(tbl[i].e_d));
      check($sformatf("v%0d.full", i),      int'(bus.full),      int'(tbl[i].e_f));
      check($sformatf("v%0d.level", i),     int'(bus.level),     int'(tbl[i].e_l));
    end

    // Fill to 17 words; 18th push dropped
    do_reset();
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b0);
      if (i == 16) begin
        check("fill.full_at_16", int'(bus.full), 0);
        check("fill.we_at_16", int'(bus.ram_we), 1);
      end
      if (i == 17) begin
        check("fill.full_at_17", int'(bus.full), 1);
        check("fill.we_at_17", int'(bus.ram_we), 0);
        check("fill.level_at_17", int'(bus.level), 17);
      end
      if (i <= 16) q.push_back(8'(i));
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("fill.level_after_drop", int'(bus.level), 17);
    check("fill.full_held", int'(bus.full), 1);
`ifdef UART_FIFO_CTRL_STATUS_EN
    check("ovf.set", int'(overflow), 1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("ovf.held", int'(overflow), 1);
    status_clr = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b0);
    status_clr = 1'b0;
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("ovf.cleared", int'(overflow), 0);
    status_clr = 1'b1;
    step(1'b0, 1'b1, 8'h77, 1'b0);
    status_clr = 1'b0;
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("ovf.set_beats_clr", int'(overflow), 1);
    check("ovf.level_same", int'(bus.level), 17);
`endif
    drain("fill", 80);
    check("fill.pop_count", n_popped, 17);

    // Continuous pop on 5 words: one word per two cycles
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 8'(8'h50 + i), 1'b0);
      q.push_back(8'(8'h50 + i));
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
`ifdef UART_FIFO_CTRL_STATUS_EN
    check("cpop.udf_clear", int'(underflow), 0);
`endif
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      check($sformatf("cpop.valid%0d", k), int'(bus.rd_valid), (k < 10 && (k % 2) == 0) ? 1 : 0);
      if (bus.rd_valid && q.size() > 0)
        check($sformatf("cpop.data%0d", k), int'(bus.rd_data), int'(q.pop_front()));
    end
    check("cpop.all_out", q.size(), 0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("cpop.level", int'(bus.level), 0);
`ifdef UART_FIFO_CTRL_STATUS_EN
    check("cpop.udf_set", int'(underflow), 1);
`endif

    // Interleaved traffic: 40 words, pointers wrap twice
    do_reset();
    for (int c = 0; c < 80; c++) begin
      step(1'b0, (c % 2) == 0, 8'(8'h80 + c / 2), 1'b1);
      if (bus.rd_valid) begin
        if (q.size() == 0) check("wrap.spurious_word", 1, 0);
        else begin
          check($sformatf("wrap.data%0d", n_popped), int'(bus.rd_data), int'(q.pop_front()));
          n_popped++;
        end
      end
      if ((c % 2) == 0) begin
        check($sformatf("wrap.we%0d", c), int'(bus.ram_we), 1);
        q.push_back(8'(8'h80 + c / 2));
      end
    end
    drain("wrap", 40);
    check("wrap.pop_count", n_popped, 40);

    // Flush with 7 words held and a fetch in flight
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("flush.pre_valid", int'(bus.rd_valid), 1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("flush.pre_level", int'(bus.level), 7);
    check("flush.pre_pending_valid", int'(bus.rd_valid), 0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("flush.level", int'(bus.level), 0);
    check("flush.valid", int'(bus.rd_valid), 0);
    check("flush.full", int'(bus.full), 0);
    step(1'b0, 1'b1, 8'h3C, 1'b0);
    check("flush.valid_no_stale", int'(bus.rd_valid), 0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("flush.new_valid", int'(bus.rd_valid), 1);
    check("flush.new_data", int'(bus.rd_data), 8'h3C);
    check("flush.new_level", int'(bus.level), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
